// File: rtl/pattern_gen.sv
// pattern_gen: per-pixel test-pattern colour source.
//
// Answers each pixel request (req with col/row) one cycle later with a registered
// colour on next_color, with valid marking the answering cycle. The pattern is
// picked by mode_q. mode_q is reloaded from mode only on frame_start, so a
// pattern change never tears mid-frame.
//
// Build option: define PATTERN_GEN_SNOW_EN to build the 30-bit LFSR for the
// "snow" pattern. When it is left undefined, no LFSR is built and mode 2
// outputs 0 on every request.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          pixel request; its colour appears on the next cycle
//   col, row     pixel coordinates (no visible-area range check)
//   switches     user foreground colour
//   mode         requested pattern, sampled only on frame_start
//   frame_start  single-cycle start-of-frame pulse
//   next_color   registered pixel colour; holds between requests
//   valid        high the cycle after a req cycle
//
// Pattern modes (mode_q):
//   mode          | meaning
//   MODE_CHECKER  | static checkerboard, tile edge 2**TILE_LOG2 pixels
//   MODE_BARS     | vertical bars from the top 3 column bits
//   MODE_SNOW     | LFSR noise (0 when snow is not built)
//   MODE_SCROLL   | checkerboard shifted by scroll_q columns per frame
module pattern_gen #(
  parameter int COLOR_W   = 8,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10,
  parameter int TILE_LOG2 = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [COL_W-1:0]   col,
  input  logic [ROW_W-1:0]   row,
  input  logic [COLOR_W-1:0] switches,
  input  logic [1:0]         mode,
  input  logic               frame_start,
  output logic [COLOR_W-1:0] next_color,
  output logic               valid
);

  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_SNOW    = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_e;

  mode_e              mode_q;
  logic [COL_W-1:0]   scroll_q, scroll_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               valid_q;

  logic [COL_W-1:0]   sc;
  logic [2:0]         bar;
  logic               unused_bits;

`ifdef PATTERN_GEN_SNOW_EN
  logic [29:0]        lfsr_q, lfsr_d;
  logic               lfsr_fb;

  assign lfsr_fb = lfsr_q[29] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
  assign lfsr_d  = {lfsr_q[28:0], lfsr_fb};
`endif

  // Only single bits of col/row/sc pick the pattern. The remaining bits are
  // intentionally unused.
  assign unused_bits = ^{col, row, sc, bar[2:1]};

  always_comb begin
    scroll_d = scroll_q + COL_W'(1);
    sc       = col + scroll_q;          // wraps modulo 2**COL_W
    bar      = col[COL_W-1 -: 3];
    color_d  = '0;
    case (mode_q)
      MODE_CHECKER: color_d = (col[TILE_LOG2] ^ row[TILE_LOG2]) ? '0 : switches;
      MODE_BARS:    color_d = bar[0] ? switches : ~switches;
`ifdef PATTERN_GEN_SNOW_EN
      MODE_SNOW:    color_d = lfsr_q[COLOR_W-1:0];
`else
      MODE_SNOW:    color_d = '0;
`endif
      MODE_SCROLL:  color_d = (sc[TILE_LOG2] ^ row[TILE_LOG2]) ? '0 : switches;
      default:      color_d = '0;
    endcase
  end

  // Every branch reads mode_q and scroll_q before they are updated. A request
  // in the same cycle as frame_start therefore still uses the old frame's
  // settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_CHECKER;
      scroll_q <= '0;
      color_q  <= '0;
      valid_q  <= 1'b0;
`ifdef PATTERN_GEN_SNOW_EN
      lfsr_q   <= 30'h0000_0001;
`endif
    end else begin
      valid_q <= req;
      if (req) begin
        color_q <= color_d;
      end
      if (frame_start) begin
        mode_q   <= mode_e'(mode);
        scroll_q <= scroll_d;
      end
`ifdef PATTERN_GEN_SNOW_EN
      if (req && (mode_q == MODE_SNOW)) begin
        lfsr_q <= lfsr_d;
      end
`endif
    end
  end

  assign next_color = color_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_pattern_gen.sv
module tb_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [9:0] col;
  logic [9:0] row;
  logic [7:0] switches;
  logic [1:0] mode;
  logic       frame_start;
  logic [7:0] next_color;
  logic       valid;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  pattern_gen #(
    .COLOR_W  (8),
    .COL_W    (10),
    .ROW_W    (10),
    .TILE_LOG2(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .col        (col),
    .row        (row),
    .switches   (switches),
    .mode       (mode),
    .frame_start(frame_start),
    .next_color (next_color),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_color(input string tag, input logic [7:0] expv);
    vectors++;
    assert (next_color === expv) else begin
      miscompares++;
      $error("FAIL %s: next_color=%h expected=%h", tag, next_color, expv);
    end
  endtask

  task automatic check_valid(input string tag, input logic expv);
    vectors++;
    assert (valid === expv) else begin
      miscompares++;
      $error("FAIL %s: valid=%b expected=%b", tag, valid, expv);
    end
  endtask

  // Drive one request on the falling edge, with an optional coincident
  // frame_start. Queue its expected colour and check the result just after the
  // next rising edge.
  task automatic pixel(input string tag, input logic [9:0] c, input logic [9:0] r,
                       input logic [7:0] sw, input logic fs, input logic [7:0] expv);
    logic [7:0] e;
    @(negedge clk);
    req = 1'b1; col = c; row = r; switches = sw; frame_start = fs;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    req = 1'b0; frame_start = 1'b0;
    e = exp_q.pop_front();
    check_valid({tag, "_valid"}, 1'b1);
    check_color(tag, e);
  endtask

  task automatic idle_check(input string tag, input logic [7:0] hold_v);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check_valid({tag, "_valid"}, 1'b0);
    check_color({tag, "_hold"}, hold_v);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; req = 1'b0; col = '0; row = '0;
    switches = 8'hA5; mode = 2'd0; frame_start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_color("reset_color", 8'h00);
    check_valid("reset_valid", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Checker with the reset mode.
    pixel("chk_0_0",   10'd0,  10'd0,  8'hA5, 1'b0, 8'hA5);
    pixel("chk_64_0",  10'd64, 10'd0,  8'hA5, 1'b0, 8'h00);
    pixel("chk_64_64", 10'd64, 10'd64, 8'hA5, 1'b0, 8'hA5);
    pixel("chk_0_64",  10'd0,  10'd64, 8'h3C, 1'b0, 8'h00);
    idle_check("idle1", 8'h00);

    // Mode input alone must not change the pattern.
    mode = 2'd1;
    pixel("nofs_bars", 10'd64, 10'd0, 8'hA5, 1'b0, 8'h00);
    // frame_start together with req: old mode for this request, new mode for the next.
    pixel("fs_coinc", 10'd64, 10'd0, 8'hA5, 1'b1, 8'h00);
    pixel("bars_64",  10'd64, 10'd0, 8'hA5, 1'b0, 8'h5A);
    pixel("bars_128", 10'd128, 10'd0, 8'h0F, 1'b0, 8'h0F);
    pixel("bars_0",   10'd0,  10'd0, 8'h0F, 1'b0, 8'hF0);
    pixel("bars_896", 10'd896, 10'd5, 8'h0F, 1'b0, 8'h0F);

    // Scroll: one pulse has already happened, so scroll is now 1.
    mode = 2'd3;
    frames(1);                       // scroll = 2, mode_q = 3
    pixel("scr2_0_0", 10'd0, 10'd0, 8'hA5, 1'b0, 8'hA5);
    frames(62);                      // scroll = 64
    pixel("scr64_0_0",   10'd0,   10'd0,  8'hA5, 1'b0, 8'h00);
    pixel("scr64_0_64",  10'd0,   10'd64, 8'hA5, 1'b0, 8'hA5);
    pixel("scr64_960_0", 10'd960, 10'd0,  8'hA5, 1'b0, 8'hA5);
    frames(960);                     // scroll wraps to 0
    pixel("scr_wrap_0_0",  10'd0,  10'd0, 8'hA5, 1'b0, 8'hA5);
    pixel("scr_wrap_64_0", 10'd64, 10'd0, 8'hA5, 1'b0, 8'h00);

    // Asynchronous reset asserted between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_color("async_rst_color", 8'h00);
    check_valid("async_rst_valid", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // mode input is still 3, but mode_q was cleared, so the checker is back.
    pixel("post_rst_64_0", 10'd64, 10'd0, 8'hA5, 1'b0, 8'h00);
    pixel("post_rst_0_0",  10'd0,  10'd0, 8'hA5, 1'b0, 8'hA5);

    // Snow mode.
    mode = 2'd2;
    frames(1);
`ifdef PATTERN_GEN_SNOW_EN
    pixel("snow1", 10'd3, 10'd7, 8'hA5, 1'b0, 8'h01);
    idle_check("snow_idle", 8'h01);
    pixel("snow2", 10'd3, 10'd7, 8'hA5, 1'b0, 8'h03);
    idle_check("snow_idle2", 8'h03);
    pixel("snow3", 10'd3, 10'd7, 8'hA5, 1'b0, 8'h07);
`else
    pixel("snow_off1", 10'd0,  10'd0, 8'hA5, 1'b0, 8'h00);
    idle_check("snow_idle", 8'h00);
    pixel("snow_off2", 10'd64, 10'd0, 8'hFF, 1'b0, 8'h00);
    pixel("snow_off3", 10'd5,  10'd9, 8'h5A, 1'b0, 8'h00);
`endif

    // Switch back to the checker to make sure the other modes still work.
    mode = 2'd0;
    frames(1);
    pixel("back_chk", 10'd0, 10'd0, 8'hC3, 1'b0, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
